// File: rtl/prefix_adder_pkg.sv
// prefix_adder_pkg: kpg encoding, prefix operator and pipeline sizing helpers
package prefix_adder_pkg;

    typedef enum logic [1:0] {
        KILL = 2'b00,
        PROP = 2'b10,
        GEN  = 2'b11
    } kpg_t;

    function automatic kpg_t kpg_combine(kpg_t hi, kpg_t lo);
        return (hi == PROP) ? lo : hi;
    endfunction

    // position 0 carries the carry-in seed, so there are WIDTH+1 prefix positions
    function automatic int prefix_levels(int width);
        return $clog2(width + 1);
    endfunction

    function automatic int prefix_lat(int width, int lps);
        return (prefix_levels(width) + lps - 1) / lps + 1;
    endfunction

endpackage

// File: rtl/prefix_adder_pl_kpg_cell.sv
// kpg_cell: combinational Kogge-Stone prefix operator on kpg pairs
module kpg_cell
    import prefix_adder_pkg::*;
(
    input  logic [1:0] hi,
    input  logic [1:0] lo,
    output logic [1:0] y
);

    assign y = kpg_combine(kpg_t'(hi), kpg_t'(lo));

endmodule

// File: rtl/prefix_adder_pl.sv
// prefix_adder_pl: pipelined Kogge-Stone adder/subtractor with valid/ready on both sides
// Define PREFIX_ADDER_FLAGS_EN to add registered zero/negative/overflow outputs.
module prefix_adder_pl
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int LEVELS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef PREFIX_ADDER_FLAGS_EN
    output logic             zero,
    output logic             negative,
    output logic             overflow,
`endif
    output logic             cout
);

    localparam int L = prefix_levels(WIDTH);
    localparam int S = prefix_lat(WIDTH, LEVELS_PER_STAGE) - 1;

    logic [WIDTH-1:0]      bp;
    logic [WIDTH:0][1:0]   gen;
    logic [WIDTH:0][1:0]   kp_q [0:S-1];
    logic [WIDTH-1:0]      x_q  [0:S-1];
    logic [WIDTH:0][1:0]   src  [0:L-1];
    logic [WIDTH:0][1:0]   lv   [1:L];
    logic [WIDTH:0]        cy;
    logic [WIDTH-1:0]      nxt;
    logic [S:0]            v;
    logic [S:0]            v_in;
    logic [S:0]            rdy;

    assign bp = op_sub ? ~b : b;

    always_comb begin
        gen[0] = {2{op_sub | cin}};
        for (int i = 0; i < WIDTH; i++) gen[i+1] = {a[i] | bp[i], a[i] & bp[i]};
    end

    always_comb begin
        rdy[S] = !v[S] | out_ready;
        for (int s = S - 1; s >= 0; s--) rdy[s] = !v[s] | rdy[s+1];
    end

    assign v_in      = {v[S-1:0], in_valid};
    assign in_ready  = rdy[0];
    assign out_valid = v[S];

    always_ff @(posedge clk)
        if (rst) v <= '0;
        else     v <= (v & ~rdy) | (v_in & rdy);

    // stage 0 holds operands already in kpg / half-sum form
    always_ff @(posedge clk) begin
        if (rdy[0] && in_valid) begin
            kp_q[0] <= gen;
            x_q[0]  <= a ^ bp;
        end
        for (int s = 1; s < S; s++)
            if (rdy[s] && v[s-1]) begin
                kp_q[s] <= lv[s*LEVELS_PER_STAGE];
                x_q[s]  <= x_q[s-1];
            end
    end

    for (genvar k = 0; k < L; k++) begin : g_lvl
        if (k % LEVELS_PER_STAGE == 0) begin : g_reg
            assign src[k] = kp_q[k / LEVELS_PER_STAGE];
        end else begin : g_comb
            assign src[k] = lv[k];
        end
        for (genvar j = 0; j <= WIDTH; j++) begin : g_pos
            if (j >= (1 << k)) begin : g_cell
                kpg_cell u_cell (
                    .hi (src[k][j]),
                    .lo (src[k][j - (1 << k)]),
                    .y  (lv[k+1][j])
                );
            end else begin : g_pass
                assign lv[k+1][j] = src[k][j];
            end
        end
    end

    for (genvar j = 0; j <= WIDTH; j++) begin : g_cy
        assign cy[j] = |lv[L][j];
    end

    assign nxt = x_q[S-1] ^ cy[WIDTH-1:0];

    always_ff @(posedge clk)
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (rdy[S] && v[S-1]) begin
            sum  <= nxt;
            cout <= cy[WIDTH];
        end

`ifdef PREFIX_ADDER_FLAGS_EN
    always_ff @(posedge clk)
        if (rst) begin
            zero     <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else if (rdy[S] && v[S-1]) begin
            zero     <= (nxt == '0);
            negative <= nxt[WIDTH-1];
            overflow <= cy[WIDTH] ^ cy[WIDTH-1];
        end
`endif

endmodule

// File: tb/tb_prefix_adder_pl.sv
// tb_prefix_adder_pl: directed checks of latency, add/sub, streaming, back-pressure and reset
module tb_prefix_adder_pl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        op_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout;
`ifdef PREFIX_ADDER_FLAGS_EN
    logic        zero, negative, overflow;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic        vc [8];
    logic        vs [8];
    logic [16:0] ve [8];

    prefix_adder_pl #(.WIDTH(16), .LEVELS_PER_STAGE(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef PREFIX_ADDER_FLAGS_EN
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow),
`endif
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic drive(int i);
        a = va[i]; b = vb[i]; cin = vc[i]; op_sub = vs[i];
    endtask

    // one beat through an empty pipe; leaves the result presented on the output
    task automatic run1(string tag, logic [15:0] ta, logic [15:0] tb_v, logic tc, logic ts, logic [16:0] e);
        int n;
        a = ta; b = tb_v; cin = tc; op_sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        step;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            step;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd4);
        chk({tag, "_res"}, 32'({cout, sum}), 32'(e));
    endtask

    initial begin
        int got, first, last, acc, k, changes, stale;
        logic [16:0] held;
        logic seen;
        va = '{16'h1234, 16'h8000, 16'h00FF, 16'h1000, 16'h0000, 16'hABCD, 16'hABCD, 16'hFFFF};
        vb = '{16'h1111, 16'h8000, 16'h0001, 16'h0001, 16'h0001, 16'h5432, 16'h5432, 16'hFFFF};
        vc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        ve = '{17'h02345, 17'h10000, 17'h00101, 17'h10FFF, 17'h0FFFF, 17'h0FFFF, 17'h10000, 17'h10000};

        step;
        step;
        rst = 1'b0;
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_ir", 32'(in_ready), 32'd1);
        chk("rst_res", 32'({cout, sum}), 32'd0);

        run1("carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000);
        step;
        chk("carry_drop", 32'(out_valid), 32'd0);
        run1("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 17'h0FFFE);
        step;
        run1("sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b1, 17'h10002);
        step;
`ifdef PREFIX_ADDER_FLAGS_EN
        run1("fl_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000);
        chk("fl_ovf_o", 32'(overflow), 32'd1);
        chk("fl_ovf_n", 32'(negative), 32'd1);
        chk("fl_ovf_z", 32'(zero), 32'd0);
        step;
        run1("fl_zero", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000);
        chk("fl_zero_z", 32'(zero), 32'd1);
        chk("fl_zero_o", 32'(overflow), 32'd0);
        step;
`endif

        got = 0; first = -1; last = -1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = (i < 8);
            if (i < 8) begin
                drive(i);
                chk($sformatf("b2b_ir%0d", i), 32'(in_ready), 32'd1);
            end
            if (out_valid) begin
                if (first < 0) first = i;
                last = i;
                if (got < 8) chk($sformatf("b2b_res%0d", got), 32'({cout, sum}), 32'(ve[got]));
                got++;
            end
            step;
        end
        in_valid = 1'b0;
        chk("b2b_cnt", 32'(got), 32'd8);
        chk("b2b_first", 32'(first), 32'd4);
        chk("b2b_span", 32'(last - first), 32'd7);

        out_ready = 1'b0;
        acc = 0; k = 0; changes = 0; seen = 1'b0; held = '0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            drive(k);
            if (out_valid) begin
                if (!seen) held = {cout, sum};
                else if ({cout, sum} !== held) changes++;
                seen = 1'b1;
            end
            if (in_ready) begin
                acc++;
                k++;
            end
            step;
        end
        in_valid = 1'b0;
        chk("bp_acc", 32'(acc), 32'd4);
        chk("bp_ir", 32'(in_ready), 32'd0);
        chk("bp_ov", 32'(out_valid), 32'd1);
        chk("bp_held", 32'(held), 32'(ve[0]));
        chk("bp_stable", 32'(changes), 32'd0);
        out_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) begin
                if (got < 4) chk($sformatf("bp_res%0d", got), 32'({cout, sum}), 32'(ve[got]));
                got++;
            end
            step;
        end
        chk("bp_cnt", 32'(got), 32'd4);

        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            drive(i + 4);
            step;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("mid_ov", 32'(out_valid), 32'd0);
        chk("mid_res", 32'({cout, sum}), 32'd0);
        chk("mid_ir", 32'(in_ready), 32'd1);
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) stale++;
            step;
        end
        chk("mid_stale", 32'(stale), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
